// File: rtl/multi_channel_toggle_reduce.sv
// multi_channel_toggle_reduce
//   N independent square-wave channels, each with a runtime-loadable period,
//   feeding a registered reduction gate (AND/OR/XOR/NAND) whose rising edges
//   are counted by a saturating counter.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   run               1 = channel counters advance, 0 = channels hold
//   clr               synchronous clear of counters, ch_out, red_out, rise_cnt
//   mode              00 AND, 01 OR, 10 XOR, 11 NAND
//   ld_en/ld_ch/ld_val period load strobe, channel index, new period
//   ch_out            per-channel toggle outputs
//   red_out, red_n    registered reduction of ch_out and its complement
//   rise_cnt          saturating count of red_out 0->1 transitions

// One toggle channel: counts 0..per, toggles its output at terminal count.
// A load restarts the count and wins over the terminal-count toggle.
module mctr_channel #(
    parameter int CW      = 8,
    parameter int DEF_PER = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    input  logic          clr,
    input  logic          ld,
    input  logic [CW-1:0] ld_val,
    output logic          tgl
);
    logic [CW-1:0] per;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per <= CW'(DEF_PER);
            cnt <= '0;
            tgl <= 1'b0;
        end else if (clr) begin
            // clear still honours a simultaneous period write
            cnt <= '0;
            tgl <= 1'b0;
            if (ld) per <= ld_val;
        end else if (ld) begin
            per <= ld_val;
            cnt <= '0;
        end else if (run) begin
            if (cnt == per) begin
                cnt <= '0;
                tgl <= ~tgl;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

module multi_channel_toggle_reduce #(
    parameter int N       = 3,
    parameter int CW      = 8,
    parameter int RW      = 16,
    parameter int DEF_PER = 0,
    localparam int LW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    input  logic          clr,
    input  logic [1:0]    mode,
    input  logic          ld_en,
    input  logic [LW-1:0] ld_ch,
    input  logic [CW-1:0] ld_val,
    output logic [N-1:0]  ch_out,
    output logic          red_out,
    output logic          red_n,
    output logic [RW-1:0] rise_cnt
);
    logic [N-1:0] ld_hit;
    logic         red_next;

    // Out-of-range ld_ch matches no channel, so the load is dropped.
    for (genvar i = 0; i < N; i++) begin : g_ch
        assign ld_hit[i] = ld_en && (32'(ld_ch) == i);

        mctr_channel #(
            .CW      (CW),
            .DEF_PER (DEF_PER)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .run    (run),
            .clr    (clr),
            .ld     (ld_hit[i]),
            .ld_val (ld_val),
            .tgl    (ch_out[i])
        );
    end

    always_comb begin
        red_next = 1'b0;
        case (mode)
            2'b00:   red_next = &ch_out;
            2'b01:   red_next = |ch_out;
            2'b10:   red_next = ^ch_out;
            default: red_next = ~&ch_out;
        endcase
    end

    // Rise detection compares the current register with the value it is
    // about to take, so mode-induced transitions are counted too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red_out  <= 1'b0;
            rise_cnt <= '0;
        end else if (clr) begin
            red_out  <= 1'b0;
            rise_cnt <= '0;
        end else begin
            red_out <= red_next;
            if (!red_out && red_next && (rise_cnt != {RW{1'b1}}))
                rise_cnt <= rise_cnt + RW'(1);
        end
    end

    assign red_n = ~red_out;
endmodule

// File: tb/tb_multi_channel_toggle_reduce.sv
// Self-checking bench: behavioural model checked every cycle, plus literal
// pins from hand-worked waveforms. A second instance with RW=2 shares the
// stimulus to exercise rise-counter saturation.
module tb_multi_channel_toggle_reduce;
    localparam int N  = 3;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          run = 1'b0;
    logic          clr = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic          ld_en = 1'b0;
    logic [1:0]    ld_ch = '0;
    logic [CW-1:0] ld_val = '0;

    logic [N-1:0]  ch_out, ch_out2;
    logic          red_out, red_n, red_out2, red_n2;
    logic [15:0]   rise_cnt;
    logic [1:0]    rise_cnt2;

    int checks = 0;
    int errors = 0;

    multi_channel_toggle_reduce #(.N(N), .CW(CW), .RW(16), .DEF_PER(0)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .clr(clr), .mode(mode),
        .ld_en(ld_en), .ld_ch(ld_ch), .ld_val(ld_val),
        .ch_out(ch_out), .red_out(red_out), .red_n(red_n), .rise_cnt(rise_cnt)
    );

    multi_channel_toggle_reduce #(.N(N), .CW(CW), .RW(2), .DEF_PER(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .run(run), .clr(clr), .mode(mode),
        .ld_en(ld_en), .ld_ch(ld_ch), .ld_val(ld_val),
        .ch_out(ch_out2), .red_out(red_out2), .red_n(red_n2), .rise_cnt(rise_cnt2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int       per_m [N];
    int       cnt_m [N];
    bit [N-1:0] ch_m = '0;
    bit       red_m = 1'b0;
    int       rise_m = 0;   // unbounded count; saturation applied at compare

    function automatic bit reduce(input bit [1:0] m, input bit [N-1:0] v);
        case (m)
            2'd0:    return &v;
            2'd1:    return |v;
            2'd2:    return ^v;
            default: return !(&v);
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit [N-1:0] ch_nx;
        bit         f;
        bit         hit;
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin per_m[i] = 0; cnt_m[i] = 0; end
            ch_m = '0; red_m = 1'b0; rise_m = 0;
        end else begin
            f     = reduce(mode, ch_m);
            ch_nx = ch_m;
            for (int i = 0; i < N; i++) begin
                hit = ld_en && (int'(ld_ch) == i);
                if (hit) per_m[i] = int'(ld_val);
                if (clr || hit) cnt_m[i] = 0;
                else if (run) begin
                    // toggle on every (per+1)th running edge
                    cnt_m[i] = (cnt_m[i] + 1) % (per_m[i] + 1);
                    if (cnt_m[i] == 0) ch_nx[i] = ~ch_nx[i];
                end
            end
            if (clr) begin
                ch_m = '0; red_m = 1'b0; rise_m = 0;
            end else begin
                if (!red_m && f) rise_m++;
                red_m = f;
                ch_m  = ch_nx;
            end
        end
    end

    // one compare process, every cycle, away from the active edge
    always @(negedge clk) begin
        chk("ch_out",    int'(ch_out),    int'(ch_m));
        chk("red_out",   int'(red_out),   int'(red_m));
        chk("red_n",     int'(red_n),     int'(!red_m));
        chk("rise_cnt",  int'(rise_cnt),  (rise_m > 65535) ? 65535 : rise_m);
        chk("rise_cnt2", int'(rise_cnt2), (rise_m > 3) ? 3 : rise_m);
        chk("red_out2",  int'(red_out2),  int'(red_m));
    end

    // advance one clock; return 2 time units after the edge
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input int ch, input int val);
        ld_en = 1'b1; ld_ch = 2'(ch); ld_val = CW'(val);
        step();
        ld_en = 1'b0;
    endtask

    logic [24:0] pat;

    initial begin
        // ---- reset with run=1, per=0: all channels toggle every edge ----
        run = 1'b1;
        step(); step();
        rst_n = 1'b1;
        step();
        chk("pin_first_ch", int'(ch_out), 7);
        chk("pin_first_red", int'(red_out), 0);
        step();
        chk("pin_second_ch", int'(ch_out), 0);
        chk("pin_second_red", int'(red_out), 1);
        chk("pin_second_rise", int'(rise_cnt), 1);

        // ---- AND pattern with per={2,1,0} ----
        run = 1'b0; clr = 1'b1;
        load(0, 0);
        clr = 1'b0;
        load(1, 1);
        load(2, 2);
        run = 1'b1;
        pat = '0;
        for (int k = 1; k <= 24; k++) begin
            step();
            pat[k] = red_out;
        end
        chk("pin_and_pattern", int'(pat), (1 << 4) | (1 << 12) | (1 << 16) | (1 << 24));
        chk("pin_and_rise", int'(rise_cnt), 4);
        chk("pin_sat_rise", int'(rise_cnt2), 3);

        // ---- async reset mid-cycle, then NAND pattern ----
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("pin_async_ch", int'(ch_out), 0);
        chk("pin_async_red", int'(red_out), 0);
        chk("pin_async_redn", int'(red_n), 1);
        chk("pin_async_rise", int'(rise_cnt), 0);
        run = 1'b0; mode = 2'b11;
        #2;
        rst_n = 1'b1;
        step();
        chk("pin_nand_red", int'(red_out), 1);
        chk("pin_nand_rise", int'(rise_cnt), 1);
        load(1, 1);
        load(2, 2);
        run = 1'b1;
        pat = '0;
        for (int k = 1; k <= 24; k++) begin
            step();
            pat[k] = red_out;
        end
        chk("pin_nand_pattern", int'(pat),
            int'(25'h1fffffe & ~((25'd1 << 4) | (25'd1 << 12) | (25'd1 << 16) | (25'd1 << 24))));

        // ---- load on terminal count: per=3 then reload 5 at cnt==3 ----
        run = 1'b0; clr = 1'b1;
        load(0, 3);
        clr = 1'b0; run = 1'b1;
        step(); step(); step();
        chk("pin_tc_pre", int'(ch_out[0]), 0);
        ld_en = 1'b1; ld_ch = 2'd0; ld_val = 8'd5;
        for (int k = 4; k <= 10; k++) begin
            step();
            ld_en = 1'b0;
            chk("pin_tc_load", int'(ch_out[0]), (k == 10) ? 1 : 0);
        end

        // ---- out-of-range channel load ----
        ld_en = 1'b1; ld_ch = 2'd3; ld_val = 8'd7;
        step(); step(); step();
        ld_en = 1'b0;

        // ---- hold for 10 cycles, then clear with a load ----
        run = 1'b0;
        for (int k = 0; k < 10; k++) step();
        clr = 1'b1;
        load(1, 4);
        clr = 1'b0;
        chk("pin_clr_ch", int'(ch_out), 0);
        chk("pin_clr_rise", int'(rise_cnt), 0);
        chk("pin_clr_red", int'(red_out), 0);
        run = 1'b1;
        for (int k = 0; k < 12; k++) step();

        // ---- randomized operation ----
        for (int k = 0; k < 3000; k++) begin
            run    = ($urandom_range(0, 3) != 0);
            clr    = ($urandom_range(0, 49) == 0);
            ld_en  = ($urandom_range(0, 9) == 0);
            ld_ch  = 2'($urandom_range(0, 3));
            ld_val = CW'($urandom_range(0, 5));
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
            step();
        end
        run = 1'b0; clr = 1'b0; ld_en = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
